// File: rtl/oric_pkg.sv
// Shared Oric definitions: tape scheduler states and FIFO entry layout.
// Used by the tape RAM scheduler and its write FIFO.
package oric_pkg;

  localparam int TAPE_ENTRY_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tape_entry_t;

endpackage

// File: rtl/tape_wr_fifo.sv
// Sync FIFO for tape bytes. In: clk, reset_n, flush, push, wdata, pop.
// Out: rdata (head, combinational), full, empty. Push ignored when full.
module tape_wr_fifo
  import oric_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = TAPE_ENTRY_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit separates the full and empty cases.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tape_ram_sched.sv
// Tape RAM scheduler: queues parser bytes, writes them in free RAM slots
// (CPU wins), holds the CPU while loading, pulses load_done/autorun_req.
module tape_ram_sched
  import oric_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        tape_complete,
  input  logic        autostart,
  input  logic        ram_slot_free,
  input  logic        cpu_ram_req,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        autorun_req,
  output logic        overflow,
  output logic [15:0] bytes_written
);

  sched_state_e state_q, state_d;

  logic        dl_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  din_q;
  logic        ovf_q;
  logic [15:0] cnt_q;

  logic        dl_rise;
  logic        dl_fall;
  logic        active;
  logic        abort;
  logic        start;
  logic        push;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  tape_entry_t wentry;
  tape_entry_t rentry;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign active  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign abort   = active & dl_fall & ~tape_complete;
  assign start   = (state_q == ST_IDLE) & dl_rise;

  // Full is judged before any pop of the same cycle.
  assign push = active & ~abort & tape_wr & ~full;
  assign drop = active & tape_wr & full;
  assign pop  = active & ~abort & ~empty &
                ram_slot_free & ~cpu_ram_req;

  assign wentry = {tape_addr, tape_dout};

  tape_wr_fifo #(
    .DEPTH (DEPTH),
    .W     (TAPE_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .push    (push),
    .wdata   (wentry),
    .pop     (pop),
    .rdata   (rentry),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dl_rise) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)              state_d = ST_ABORT;
        else if (tape_complete) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait for the last registered write to leave.
        if (abort)                       state_d = ST_ABORT;
        else if (empty && !we_q && !push) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dl_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      we_q    <= pop;
      if (pop) begin
        addr_q <= rentry.addr;
        din_q  <= rentry.data;
      end
      if (start)     ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      if (start)     cnt_q <= '0;
      else if (pop)  cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ram_we        = we_q;
  assign ram_addr      = addr_q;
  assign ram_din       = din_q;
  assign overflow      = ovf_q;
  assign bytes_written = cnt_q;
  assign cpu_hold      = (state_q == ST_LOAD) ||
                         (state_q == ST_DRAIN) ||
                         (state_q == ST_DONE);
  assign load_done     = (state_q == ST_DONE);
  assign autorun_req   = (state_q == ST_DONE) & autostart;

endmodule

// File: tb/tb_tape_ram_sched.sv
// Bench for tape_ram_sched: vector table, directed corner sequences
// and random loads against a queue-based reference model.
module tb_tape_ram_sched;

  localparam int DEPTH = 8;
  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;
  localparam int P_ABORT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl, wr, cmp, ast, slot, cpu;
  logic [15:0] taddr;
  logic [7:0]  tdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we, cpu_hold, load_done, autorun_req, overflow;
  logic [15:0] bytes_written;

  always #5 clk = ~clk;

  tape_ram_sched #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (rst_n),
    .ioctl_download (dl),
    .tape_wr        (wr),
    .tape_addr      (taddr),
    .tape_dout      (tdata),
    .tape_complete  (cmp),
    .autostart      (ast),
    .ram_slot_free  (slot),
    .cpu_ram_req    (cpu),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .cpu_hold       (cpu_hold),
    .load_done      (load_done),
    .autorun_req    (autorun_req),
    .overflow       (overflow),
    .bytes_written  (bytes_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a byte queue plus load phase.
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        mq[$];
  int          ph;
  bit          m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_din;
  logic [15:0] m_cnt;
  bit          m_ovf;
  bit          m_dlp;
  int          n_we;
  logic [15:0] wlog[$];

  function void model_reset();
    mq.delete();
    ph     = P_IDLE;
    m_we   = 0;
    m_addr = '0;
    m_din  = '0;
    m_cnt  = '0;
    m_ovf  = 0;
    m_dlp  = 0;
  endfunction

  function void model_update();
    bit   rise, fall, act, abrt, full, empty, pop, push;
    int   nph;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise  = dl && !m_dlp;
    fall  = !dl && m_dlp;
    act   = (ph == P_LOAD) || (ph == P_DRAIN);
    abrt  = act && fall && !cmp;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    pop   = act && !abrt && !empty && slot && !cpu;
    push  = act && !abrt && wr && !full;
    nph   = ph;
    case (ph)
      P_IDLE: if (rise) begin
        nph   = P_LOAD;
        m_cnt = '0;
        m_ovf = 0;
      end
      P_LOAD: begin
        if (abrt)     nph = P_ABORT;
        else if (cmp) nph = P_DRAIN;
      end
      P_DRAIN: begin
        if (abrt) nph = P_ABORT;
        else if (empty && !m_we && !push) nph = P_DONE;
      end
      default: nph = P_IDLE;
    endcase
    if (act && wr && full) m_ovf = 1;
    m_we = 0;
    if (pop) begin
      e      = mq.pop_front();
      m_we   = 1;
      m_addr = e.a;
      m_din  = e.d;
      m_cnt  = m_cnt + 16'd1;
    end
    if (push) begin
      e.a = taddr;
      e.d = tdata;
      mq.push_back(e);
    end
    if (abrt) mq.delete();
    m_dlp = dl;
    ph    = nph;
  endfunction

  task automatic check_model();
    bit hold;
    hold = (ph == P_LOAD) || (ph == P_DRAIN) || (ph == P_DONE);
    chk("ram_we", ram_we, m_we);
    if (m_we) begin
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_din", ram_din, m_din);
    end
    chk("cpu_hold", cpu_hold, hold);
    chk("load_done", load_done, ph == P_DONE);
    chk("autorun_req", autorun_req, (ph == P_DONE) && ast);
    chk("overflow", overflow, m_ovf);
    chk("bytes_written", bytes_written, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
    if (ram_we) begin
      n_we++;
      wlog.push_back(ram_addr);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      if (load_done) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d);
    wr    = 1;
    taddr = a;
    tdata = d;
    step();
    wr    = 0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_we"}, ram_we, 0);
    chk({nm, "_addr"}, ram_addr, 0);
    chk({nm, "_din"}, ram_din, 0);
    chk({nm, "_hold"}, cpu_hold, 0);
    chk({nm, "_done"}, load_done, 0);
    chk({nm, "_autorun"}, autorun_req, 0);
    chk({nm, "_ovf"}, overflow, 0);
    chk({nm, "_cnt"}, bytes_written, 0);
  endtask

  typedef struct {
    logic        dl, wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        cmp, slot;
    logic        e_we;
    logic [15:0] e_a;
    logic [7:0]  e_d;
    logic        e_hold, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(
    logic i_dl, logic i_wr, logic [15:0] i_a, logic [7:0] i_d,
    logic i_cmp, logic i_slot, logic x_we, logic [15:0] x_a,
    logic [7:0] x_d, logic x_hold, logic x_done, logic [15:0] x_cnt);
    vec_t v;
    v.dl = i_dl; v.wr = i_wr; v.a = i_a; v.d = i_d;
    v.cmp = i_cmp; v.slot = i_slot;
    v.e_we = x_we; v.e_a = x_a; v.e_d = x_d;
    v.e_hold = x_hold; v.e_done = x_done; v.e_cnt = x_cnt;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[10];
    int   cnt_a, cnt_b, cnt_c;
    rst_n = 0;
    dl = 0; wr = 0; cmp = 0; ast = 0; slot = 0; cpu = 0;
    taddr = '0; tdata = '0;
    n_we = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    // Four bytes, slot always free, no CPU.
    tv[0] = mk(1,0,16'h0000,8'h00,0,1, 0,16'h0000,8'h00,1,0,16'd0);
    tv[1] = mk(1,1,16'h0500,8'hA0,0,1, 0,16'h0000,8'h00,1,0,16'd0);
    tv[2] = mk(1,1,16'h0501,8'hA1,0,1, 1,16'h0500,8'hA0,1,0,16'd1);
    tv[3] = mk(1,1,16'h0502,8'hA2,0,1, 1,16'h0501,8'hA1,1,0,16'd2);
    tv[4] = mk(1,1,16'h0503,8'hA3,0,1, 1,16'h0502,8'hA2,1,0,16'd3);
    tv[5] = mk(1,0,16'h0000,8'h00,1,1, 1,16'h0503,8'hA3,1,0,16'd4);
    tv[6] = mk(1,0,16'h0000,8'h00,1,1, 0,16'h0000,8'h00,1,0,16'd4);
    tv[7] = mk(1,0,16'h0000,8'h00,1,1, 0,16'h0000,8'h00,1,1,16'd4);
    tv[8] = mk(1,0,16'h0000,8'h00,1,1, 0,16'h0000,8'h00,0,0,16'd4);
    tv[9] = mk(0,1,16'h0999,8'h99,0,1, 0,16'h0000,8'h00,0,0,16'd4);
    for (int i = 0; i < 10; i++) begin
      dl = tv[i].dl; wr = tv[i].wr; taddr = tv[i].a; tdata = tv[i].d;
      cmp = tv[i].cmp; slot = tv[i].slot;
      step();
      chk($sformatf("t1_we[%0d]", i), ram_we, tv[i].e_we);
      if (tv[i].e_we) begin
        chk($sformatf("t1_addr[%0d]", i), ram_addr, tv[i].e_a);
        chk($sformatf("t1_din[%0d]", i), ram_din, tv[i].e_d);
      end
      chk($sformatf("t1_hold[%0d]", i), cpu_hold, tv[i].e_hold);
      chk($sformatf("t1_done[%0d]", i), load_done, tv[i].e_done);
      chk($sformatf("t1_cnt[%0d]", i), bytes_written, tv[i].e_cnt);
    end
    wr = 0;
    step();

    // Autostart high at completion.
    dl = 1; step();
    strobe(16'h0600, 8'h55);
    cmp = 1; ast = 1;
    wait_done("t4_done_seen", 20);
    chk("t4_autorun", autorun_req, 1);
    dl = 0; cmp = 0; ast = 0;
    step(); step();

    // CPU owns RAM for 20 cycles while 3 bytes arrive.
    dl = 1; step();
    cpu = 1; slot = 1;
    n_we = 0; cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2 || i == 5 || i == 8) begin
        wr = 1; taddr = 16'h0800 + 16'(i); tdata = 8'(i);
      end
      step();
      wr = 0;
      if (!cpu_hold) cnt_a++;
    end
    chk("t2_no_we_in_window", n_we, 0);
    cpu = 0; cmp = 1;
    cnt_b = 0;
    for (int i = 0; i < 30 && !load_done; i++) begin
      step();
      if (!cpu_hold) cnt_a++;
    end
    chk("t2_done_seen", load_done, 1);
    chk("t2_writes", n_we, 3);
    chk("t2_hold_low_cycles", cnt_a, 0);
    dl = 0; cmp = 0;
    step(); step();

    // Nine bytes into a closed slot: ninth is dropped.
    dl = 1; step();
    slot = 0;
    for (int i = 0; i < 9; i++) strobe(16'h0700 + 16'(i), 8'(i));
    step();
    chk("t3_overflow", overflow, 1);
    wlog.delete();
    slot = 1; cmp = 1;
    wait_done("t3_done_seen", 40);
    chk("t3_bytes", bytes_written, 8);
    cnt_c = 0;
    foreach (wlog[k]) if (wlog[k] == 16'h0708) cnt_c++;
    chk("t3_ninth_never", cnt_c, 0);
    chk("t3_log_size", wlog.size(), 8);
    dl = 0; cmp = 0;
    step(); step();

    // Download drops after 2 of 5 bytes.
    dl = 1; step();
    slot = 0;
    strobe(16'h0900, 8'h11);
    strobe(16'h0901, 8'h22);
    dl = 0;
    step();
    chk("t5_hold_next", cpu_hold, 0);
    slot = 1;
    n_we = 0; cnt_a = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (load_done) cnt_a++;
    end
    chk("t5_no_we", n_we, 0);
    chk("t5_no_done", cnt_a, 0);

    // Reset mid-drain with 3 bytes queued.
    dl = 1; step();
    slot = 0;
    strobe(16'h0A00, 8'h01);
    strobe(16'h0A01, 8'h02);
    strobe(16'h0A02, 8'h03);
    cmp = 1; step(); step();
    chk("t6_pre_hold", cpu_hold, 1);
    rst_n = 0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(negedge clk);
    dl = 0; cmp = 0;
    step(); step();
    rst_n = 1;
    slot = 1;
    n_we = 0;
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_we_after", n_we, 0);

    // Random loads against the model.
    for (int it = 0; it < 12; it++) begin
      int nbytes, abort_at, sent;
      nbytes   = $urandom_range(1, 20);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nbytes) : -1;
      sent     = 0;
      dl = 1; step();
      while (sent < nbytes) begin
        slot = ($urandom_range(0, 9) < 7);
        cpu  = ($urandom_range(0, 9) < 3);
        ast  = $urandom_range(0, 1);
        wr   = $urandom_range(0, 1);
        if (wr) begin
          taddr = 16'($urandom);
          tdata = 8'($urandom);
          sent++;
        end
        step();
        wr = 0;
        if (sent == abort_at) break;
      end
      wr = 0;
      if (abort_at >= 0) begin
        dl = 0; cmp = 0;
        repeat (3) step();
      end else begin
        bit seen;
        cmp  = 1;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
          slot = ($urandom_range(0, 9) < 7);
          cpu  = ($urandom_range(0, 9) < 3);
          ast  = $urandom_range(0, 1);
          step();
          if (load_done) seen = 1;
        end
        chk("rnd_done_seen", seen, 1);
        dl = 0; cmp = 0;
        wr = 1; taddr = 16'hBEEF; tdata = 8'hEE;
        step();
        wr = 0;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
